vlb_arbiter: RTL
================

// Module: vlb_arbiter
// PURPOSE
//  Two-requester round-robin arbiter and sequencer for the VLB memory-controller slave port.
//  Each requester presents a single read or write command with a req/gnt handshake.
//  The block serialises commands onto the slave's wr_rd_valid/wr_rd/addr/data_in pins.
//  It returns slave data_out to the owning requester with a registered rvalid pulse.
//  Sits between the test/CPU-side masters and the VLB register/memory controller.
// PARAMETERS
//  DWIDTH  32  data width; must match the slave
//  AWIDTH   8  address width; must match the slave
// PORTS
//  clk             in   1       single clock; all logic on posedge
//  rst_n           in   1       reset, asynchronous assert, active-low
//  m0_req          in   1       requester 0 command pending; held until m0_gnt
//  m0_wr_rd        in   1       1=write, 0=read; stable while m0_req && !m0_gnt
//  m0_addr         in   AWIDTH  command address; stable as above
//  m0_wdata        in   DWIDTH  write data; stable as above
//  m0_gnt          out  1       one-cycle pulse: command accepted and issued this cycle
//  m0_rvalid       out  1       one-cycle pulse: m0_rdata holds read result
//  m0_rdata        out  DWIDTH  read result; holds last value between pulses
//  m1_*            same set for requester 1
//  vlb_wr_rd_valid out  1       slave command strobe
//  vlb_wr_rd       out  1       slave direction
//  vlb_addr        out  AWIDTH  slave address
//  vlb_data_in     out  DWIDTH  slave write data
//  vlb_data_out    in   DWIDTH  slave read data; valid the cycle after the strobe
// BEHAVIOUR
//  Reset: state=IDLE, last_gnt=1 (m0 wins the first tie); all outputs 0, including rdata.
//  All outputs are registered. vlb_addr and vlb_data_in are 0 whenever vlb_wr_rd_valid=0.
//  FSM IDLE -> ISSUE -> (read ? RD_WAIT : IDLE);  RD_WAIT -> IDLE.
//  IDLE: if any req, pick a winner, latch its command, go to ISSUE. Otherwise stay in IDLE.
//  Arbitration, both req: grant != last_gnt. One req: grant it. Update last_gnt on each grant.
//  ISSUE: vlb_wr_rd_valid=1 with the latched command; winner gnt=1 for exactly this cycle.
//  RD_WAIT: capture vlb_data_out into the winner's rdata at the end of the cycle.
//  RD_WAIT: winner rvalid=1 in the following cycle, which is IDLE.
//  Latency, req seen at edge k: gnt/strobe in cycle k+1; read rvalid in cycle k+3.
//  Throughput: writes 1 per 2 cycles; reads 1 per 3 cycles. No pipelining across commands.
//  A requester may reassert req in the cycle after gnt; its new command then competes in IDLE.
//  req dropped before gnt: the command is not issued. Sampling happens only in IDLE.
//  A command already latched in ISSUE completes regardless of req.
//  The loser's req is never lost: it stays pending and wins at the next IDLE. Max wait is one command.
//  rvalid for one requester and gnt for the other never coincide (serialised FSM).
//  Reset mid-operation: no strobe, gnt or rvalid after rst_n falls.
//  Reset mid-operation: a pending read result is discarded. Outputs return to reset values immediately.
//  Illegal state encoding: recover to IDLE with no strobe.
// STRUCTURE
//  vlb_regs_pkg: add typedef enum logic [1:0] {VLB_ARB_IDLE, VLB_ARB_ISSUE, VLB_ARB_RD_WAIT} vlb_arb_state_e.
//  vlb_regs_pkg: add typedef struct packed {wr_rd, addr, wdata} vlb_cmd_t.
//  vlb_regs_pkg: add localparams VLB_ARB_M0=1'b0 and VLB_ARB_M1=1'b1.
//  Sub-module vlb_rr_arb2: combinational 2-way round-robin pick.
//  vlb_rr_arb2 ports: req[1:0] and last_gnt in; valid and winner out.
//  The top level owns the FSM, the command latch and the rdata/rvalid registers.
// TESTING
//  1. m0 write 0xA5A5_0001 @0x10, then m0 read @0x10 -> gnt k+1; strobe wr_rd=1 then 0.
//     -> m0_rvalid at k+3 of the read; m0_rdata=0xA5A5_0001.
//  2. m0 and m1 req on the same cycle, both writes, held -> grants m0, m1, m0, m1 alternate.
//     -> strobes 2 cycles apart; no double gnt.
//  3. m0 read of VLB_VOLATILE_REG_ADDR while m1 reads VLB_DATA_REG_ADDR.
//     -> each rdata returns to its own requester only; m1_rvalid never fires for m0's read.
//  4. m1 req held continuously; m0 asserts req once -> m0 granted at the next IDLE after m1's current command.
//  5. rst_n low during RD_WAIT -> no rvalid; all outputs 0.
//     -> after release, the first tie goes to m0.
//  6. m0 req pulsed for 1 cycle while the FSM is in ISSUE for m1 -> m0 is never granted.
//     -> no stray strobe.

Source files
------------

// File: rtl/vlb_regs_pkg.sv
// rtl/vlb_regs_pkg.sv - shared types and constants for the VLB slave port and its arbiter
//
// Purpose: arbiter FSM state encoding, latched-command layout, requester ids,
//          register addresses and the round-robin pick rule.
// Ports:   none (package).
package vlb_regs_pkg;

  localparam int VLB_DWIDTH = 32;
  localparam int VLB_AWIDTH = 8;

  localparam logic [VLB_AWIDTH-1:0] VLB_DATA_REG_ADDR     = 8'h04;
  localparam logic [VLB_AWIDTH-1:0] VLB_VOLATILE_REG_ADDR = 8'h08;

  typedef enum logic [1:0] {
    VLB_ARB_IDLE    = 2'd0,
    VLB_ARB_ISSUE   = 2'd1,
    VLB_ARB_RD_WAIT = 2'd2
  } vlb_arb_state_e;

  typedef struct packed {
    logic                  wr_rd;
    logic [VLB_AWIDTH-1:0] addr;
    logic [VLB_DWIDTH-1:0] wdata;
  } vlb_cmd_t;

  localparam logic VLB_ARB_M0 = 1'b0;
  localparam logic VLB_ARB_M1 = 1'b1;

  // On a tie the requester that did not win last time goes next;
  // with a single request that requester wins outright.
  function automatic logic vlb_rr_pick(input logic [1:0] req, input logic last_gnt);
    logic w_pick;
    if (req == 2'b11) begin
      w_pick = ~last_gnt;
    end else begin
      w_pick = req[1] ? VLB_ARB_M1 : VLB_ARB_M0;
    end
    return w_pick;
  endfunction

endpackage

// File: rtl/vlb_rr_arb2.sv
// rtl/vlb_rr_arb2.sv - combinational two-way round-robin pick
//
// Purpose: decide which of two requesters wins this IDLE cycle.
// Ports:
//   req[1:0]  in   pending requests, bit n = requester n
//   last_gnt  in   requester granted most recently
//   valid     out  at least one request pending
//   winner    out  chosen requester (meaningful only when valid)
module vlb_rr_arb2
  import vlb_regs_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = vlb_rr_pick(req, last_gnt);
  end

endmodule

// File: rtl/vlb_arbiter.sv
// rtl/vlb_arbiter.sv - two-requester round-robin arbiter and sequencer for the VLB slave port
//
// Purpose: serialise single read/write commands from two requesters onto the
//          VLB slave strobe interface and route read data back to the owner.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mN_req/wr_rd/addr/wdata         requester N command (held until mN_gnt)
//   mN_gnt                          one-cycle pulse, command issued this cycle
//   mN_rvalid/mN_rdata              read result pulse and held read data
//   vlb_wr_rd_valid/wr_rd/addr/
//   vlb_data_in                     slave command strobe and fields
//   vlb_data_out                    slave read data, valid the cycle after strobe
module vlb_arbiter
  import vlb_regs_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_wr_rd,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DWIDTH-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr_rd,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic              vlb_wr_rd_valid,
  output logic              vlb_wr_rd,
  output logic [AWIDTH-1:0] vlb_addr,
  output logic [DWIDTH-1:0] vlb_data_in,
  input  logic [DWIDTH-1:0] vlb_data_out
);

  vlb_arb_state_e    r_state;
  logic              r_last_gnt;
  logic              r_owner;
  logic              r_cmd_wr_rd;
  logic              r_m0_gnt;
  logic              r_m1_gnt;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;
  logic [DWIDTH-1:0] r_m0_rdata;
  logic [DWIDTH-1:0] r_m1_rdata;
  logic              r_strobe;
  logic              r_vlb_wr_rd;
  logic [AWIDTH-1:0] r_vlb_addr;
  logic [DWIDTH-1:0] r_vlb_data_in;

  logic              w_valid;
  logic              w_winner;
  logic              w_sel_wr_rd;
  logic [AWIDTH-1:0] w_sel_addr;
  logic [DWIDTH-1:0] w_sel_wdata;

  vlb_rr_arb2 u_rr (
    .req      ({m1_req, m0_req}),
    .last_gnt (r_last_gnt),
    .valid    (w_valid),
    .winner   (w_winner)
  );

  always_comb begin
    w_sel_wr_rd = (w_winner == VLB_ARB_M1) ? m1_wr_rd : m0_wr_rd;
    w_sel_addr  = (w_winner == VLB_ARB_M1) ? m1_addr  : m0_addr;
    w_sel_wdata = (w_winner == VLB_ARB_M1) ? m1_wdata : m0_wdata;
  end

  // Pulse outputs and the slave command fields default to 0 every cycle, so
  // vlb_addr/vlb_data_in are only non-zero while the strobe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= VLB_ARB_IDLE;
      r_last_gnt    <= VLB_ARB_M1;
      r_owner       <= VLB_ARB_M0;
      r_cmd_wr_rd   <= 1'b0;
      r_m0_gnt      <= 1'b0;
      r_m1_gnt      <= 1'b0;
      r_m0_rvalid   <= 1'b0;
      r_m1_rvalid   <= 1'b0;
      r_m0_rdata    <= '0;
      r_m1_rdata    <= '0;
      r_strobe      <= 1'b0;
      r_vlb_wr_rd   <= 1'b0;
      r_vlb_addr    <= '0;
      r_vlb_data_in <= '0;
    end else begin
      r_m0_gnt      <= 1'b0;
      r_m1_gnt      <= 1'b0;
      r_m0_rvalid   <= 1'b0;
      r_m1_rvalid   <= 1'b0;
      r_strobe      <= 1'b0;
      r_vlb_wr_rd   <= 1'b0;
      r_vlb_addr    <= '0;
      r_vlb_data_in <= '0;
      case (r_state)
        VLB_ARB_IDLE: begin
          if (w_valid) begin
            // Outputs for the ISSUE cycle are loaded here so they appear
            // together with the state change.
            r_owner       <= w_winner;
            r_last_gnt    <= w_winner;
            r_cmd_wr_rd   <= w_sel_wr_rd;
            r_strobe      <= 1'b1;
            r_vlb_wr_rd   <= w_sel_wr_rd;
            r_vlb_addr    <= w_sel_addr;
            r_vlb_data_in <= w_sel_wdata;
            r_m0_gnt      <= (w_winner == VLB_ARB_M0);
            r_m1_gnt      <= (w_winner == VLB_ARB_M1);
            r_state       <= VLB_ARB_ISSUE;
          end
        end
        VLB_ARB_ISSUE: begin
          r_state <= r_cmd_wr_rd ? VLB_ARB_IDLE : VLB_ARB_RD_WAIT;
        end
        VLB_ARB_RD_WAIT: begin
          if (r_owner == VLB_ARB_M1) begin
            r_m1_rdata  <= vlb_data_out;
            r_m1_rvalid <= 1'b1;
          end else begin
            r_m0_rdata  <= vlb_data_out;
            r_m0_rvalid <= 1'b1;
          end
          r_state <= VLB_ARB_IDLE;
        end
        default: begin
          r_state <= VLB_ARB_IDLE;
        end
      endcase
    end
  end

  assign m0_gnt          = r_m0_gnt;
  assign m1_gnt          = r_m1_gnt;
  assign m0_rvalid       = r_m0_rvalid;
  assign m1_rvalid       = r_m1_rvalid;
  assign m0_rdata        = r_m0_rdata;
  assign m1_rdata        = r_m1_rdata;
  assign vlb_wr_rd_valid = r_strobe;
  assign vlb_wr_rd       = r_vlb_wr_rd;
  assign vlb_addr        = r_vlb_addr;
  assign vlb_data_in     = r_vlb_data_in;

endmodule
